// File: rtl/ahb_arbiter_nm.sv
// ahb_arbiter_nm: AHB arbiter with lock hold and SPLIT masking.
// Define AHB_ARB_ROUNDROBIN_EN for round-robin; fixed priority (lowest index) otherwise.
module ahb_arbiter_nm #(
  parameter int NUM_MASTERS = 4,
  parameter int DEFAULT_MASTER = 0,
  localparam int MW = $clog2(NUM_MASTERS)
) (
  input  logic                   HCLK,
  input  logic                   HRESET,
  input  logic [NUM_MASTERS-1:0] HBUSREQx,
  input  logic [NUM_MASTERS-1:0] HLOCKx,
  input  logic [NUM_MASTERS-1:0] HSPLIT,
  input  logic [1:0]             HRESP,
  input  logic                   HREADY,
  output logic [NUM_MASTERS-1:0] HGRANTx,
  output logic [MW-1:0]          HMASTER,
  output logic                   HMASTLOCK
);
  typedef enum logic [1:0] {ST_DEFAULT, ST_OWNED, ST_LOCKED} state_t;
  state_t                 r_state, w_state_next;
  logic [NUM_MASTERS-1:0] r_grant, w_grant_next;
  logic [NUM_MASTERS-1:0] r_split_mask, w_split_next, w_split_set, w_eff;
  logic [MW-1:0]          r_master, w_owner, w_win;
  logic                   r_mastlock, w_found, w_split_rsp, w_rearb;
`ifdef AHB_ARB_ROUNDROBIN_EN
  logic [MW-1:0]          r_rr_ptr;
`endif
  assign HGRANTx   = r_grant;
  assign HMASTER   = r_master;
  assign HMASTLOCK = r_mastlock;
  always_comb begin
    w_owner = '0;
    for (int i = 0; i < NUM_MASTERS; i++)
      if (r_grant[i]) w_owner = MW'(i);
  end
  always_comb begin
    w_eff   = HBUSREQx & ~r_split_mask;
    w_found = |w_eff;
    w_win   = '0;
`ifdef AHB_ARB_ROUNDROBIN_EN
    for (int k = NUM_MASTERS; k >= 1; k--)
      if (w_eff[(int'(r_rr_ptr) + k) % NUM_MASTERS]) w_win = MW'((int'(r_rr_ptr) + k) % NUM_MASTERS);
`else
    for (int k = NUM_MASTERS - 1; k >= 0; k--)
      if (w_eff[k]) w_win = MW'(k);
`endif
  end
  always_comb begin
    w_split_rsp = (HRESP == 2'b11) && !HREADY;
    w_split_set = '0;
    if (w_split_rsp && int'(r_master) != DEFAULT_MASTER) w_split_set[r_master] = 1'b1;
    w_split_next = (r_split_mask & ~HSPLIT) | w_split_set;
    w_rearb      = HREADY && r_state != ST_LOCKED;
    w_state_next = r_state;
    w_grant_next = r_grant;
    // A SPLIT response breaks any lock so the split master can be excluded next handover.
    if (w_split_rsp && r_state == ST_LOCKED)
      w_state_next = ST_OWNED;
    else if (HREADY && r_state == ST_LOCKED && !HLOCKx[w_owner])
      w_state_next = ST_OWNED;
    else if (w_rearb) begin
      w_grant_next = w_found ? NUM_MASTERS'(1) << w_win : NUM_MASTERS'(1) << DEFAULT_MASTER;
      w_state_next = !w_found ? ST_DEFAULT : HLOCKx[w_win] ? ST_LOCKED : ST_OWNED;
    end
  end
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      r_state      <= ST_DEFAULT;
      r_grant      <= NUM_MASTERS'(1) << DEFAULT_MASTER;
      r_master     <= MW'(DEFAULT_MASTER);
      r_mastlock   <= 1'b0;
      r_split_mask <= '0;
`ifdef AHB_ARB_ROUNDROBIN_EN
      r_rr_ptr     <= MW'(DEFAULT_MASTER);
`endif
    end else begin
      r_state      <= w_state_next;
      r_grant      <= w_grant_next;
      r_split_mask <= w_split_next;
      if (HREADY) begin
        r_master   <= w_owner;
        r_mastlock <= HLOCKx[w_owner];
      end
`ifdef AHB_ARB_ROUNDROBIN_EN
      if (w_rearb && w_found) r_rr_ptr <= w_win;
`endif
    end
  end
endmodule
